// File: rtl/scm_ctrl_pkg.sv
// Shared constants and types for the SCM measurement-window sequencer.
package scm_ctrl_pkg;

  localparam logic [2:0] OFF_CTRL      = 3'd0;
  localparam logic [2:0] OFF_WIN_LEN   = 3'd1;
  localparam logic [2:0] OFF_DRAIN_LEN = 3'd2;
  localparam logic [2:0] OFF_STATUS    = 3'd3;
  localparam logic [2:0] OFF_ELAPSED   = 3'd4;
  localparam logic [2:0] OFF_RUN_PKTS  = 3'd5;
  localparam logic [31:0] REG_COUNT    = 32'd6;

  localparam logic [2:0] CFG_TYPE_WR   = 3'b010;
  localparam logic [2:0] CFG_TYPE_RD   = 3'b001;
  localparam logic [3:0] CFG_TYPE_RESP = 4'b1011;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3
  } meas_state_e;

endpackage

// File: rtl/scm_ctrl_cfg_if.sv
// Config-chain slice for the sequencer: decodes own-address words, holds
// WIN_LEN/DRAIN_LEN, answers reads in place and forwards everything else.
module scm_ctrl_cfg_if
  import scm_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h7000_0010
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] cin_data,
  input  logic         cin_data_wr,
  input  logic         cin_ready,
  output logic [133:0] cout_data,
  output logic         cout_data_wr,
  input  logic [31:0]  status,
  input  logic [31:0]  elapsed,
  input  logic [31:0]  run_pkts,
  output logic         start_p,
  output logic         abort_p,
  output logic         clear_p,
  output logic [31:0]  win_len,
  output logic [31:0]  drain_len
);

  logic        accept;
  logic [2:0]  typ;
  logic [31:0] offset;
  logic [2:0]  idx;
  logic        hit;
  logic        wr_hit;
  logic        rd_hit;
  logic        ctrl_wr;
  logic [31:0] rd_data;

  assign accept  = cin_data_wr & cin_ready;
  assign typ     = cin_data[126:124];
  assign offset  = cin_data[95:64] - BASE_ADDR;
  assign idx     = offset[2:0];
  assign hit     = offset < REG_COUNT;
  assign wr_hit  = accept && hit && (typ == CFG_TYPE_WR);
  assign rd_hit  = accept && hit && (typ == CFG_TYPE_RD);
  assign ctrl_wr = wr_hit && (idx == OFF_CTRL);

  assign start_p = ctrl_wr && cin_data[CTRL_START];
  assign abort_p = ctrl_wr && cin_data[CTRL_ABORT];
  assign clear_p = ctrl_wr && cin_data[CTRL_CLEAR];

  // Reads see register values before any update made by this same cycle.
  always_comb begin
    rd_data = '0;
    case (idx)
      OFF_WIN_LEN:   rd_data = win_len;
      OFF_DRAIN_LEN: rd_data = drain_len;
      OFF_STATUS:    rd_data = status;
      OFF_ELAPSED:   rd_data = elapsed;
      OFF_RUN_PKTS:  rd_data = run_pkts;
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_len   <= '0;
      drain_len <= '0;
    end else if (wr_hit) begin
      if (idx == OFF_WIN_LEN)   win_len   <= cin_data[31:0];
      if (idx == OFF_DRAIN_LEN) drain_len <= cin_data[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_data    <= '0;
      cout_data_wr <= 1'b0;
    end else begin
      cout_data_wr <= accept;
      if (accept) begin
        if (rd_hit)
          cout_data <= {cin_data[133:128], CFG_TYPE_RESP, cin_data[123:32], rd_data};
        else
          cout_data <= cin_data;
      end
    end
  end

endmodule

// File: rtl/scm_meas_ctrl.sv
// Measurement-window sequencer driving SCM's sent_start/sent_end levels.
// Optional macro SCM_CTRL_PKTCNT_EN builds the RUN_PKTS packet counter.
//
//   state | meaning
//   IDLE  | waiting for START, both levels low
//   RUN   | window open, ELAPSED counting
//   DRAIN | window closed, drain down-counter running
//   DONE  | measurement complete, hold until CLEAR
module scm_meas_ctrl
  import scm_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h7000_0010
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] cin_data,
  input  logic         cin_data_wr,
  output logic         cout_ready,
  output logic [133:0] cout_data,
  output logic         cout_data_wr,
  input  logic         cin_ready,
  input  logic         in_md_wr,
  output logic         out_sent_start,
  output logic         out_sent_end
);

  meas_state_e state_q, next_state;
  logic [31:0] elapsed_q;
  logic [31:0] drain_cnt_q;
  logic [31:0] run_pkts;
  logic [31:0] win_len, drain_len;
  logic        start_p, abort_p, clear_p;
  logic        zero_err_q, rej_q;
  logic        clr_cnt, load_drain, set_zero, set_rej;
  logic [31:0] status;

  assign cout_ready = cin_ready;
  assign status     = {27'b0, rej_q, zero_err_q, state_q};

  scm_ctrl_cfg_if #(.BASE_ADDR(BASE_ADDR)) u_cfg_if (
    .clk          (clk),
    .rst_n        (rst_n),
    .cin_data     (cin_data),
    .cin_data_wr  (cin_data_wr),
    .cin_ready    (cin_ready),
    .cout_data    (cout_data),
    .cout_data_wr (cout_data_wr),
    .status       (status),
    .elapsed      (elapsed_q),
    .run_pkts     (run_pkts),
    .start_p      (start_p),
    .abort_p      (abort_p),
    .clear_p      (clear_p),
    .win_len      (win_len),
    .drain_len    (drain_len)
  );

  // CLEAR overrides everything; ABORT masks a START carried in the same word.
  always_comb begin
    next_state = state_q;
    clr_cnt    = 1'b0;
    load_drain = 1'b0;
    set_zero   = 1'b0;
    set_rej    = 1'b0;
    if (clear_p) begin
      next_state = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_p && !abort_p) begin
            if (win_len != '0) begin
              next_state = ST_RUN;
              clr_cnt    = 1'b1;
            end else begin
              set_zero = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort_p || (elapsed_q >= win_len - 32'd1)) begin
            next_state = ST_DRAIN;
            load_drain = 1'b1;
          end
          set_rej = start_p && !abort_p;
        end
        ST_DRAIN: begin
          // A zero load behaves like a load of one: a single drain cycle.
          if (abort_p || (drain_cnt_q <= 32'd1)) next_state = ST_DONE;
          set_rej = start_p && !abort_p;
        end
        ST_DONE: begin
          set_rej = start_p && !abort_p;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      out_sent_start <= 1'b0;
      out_sent_end   <= 1'b0;
      elapsed_q      <= '0;
      drain_cnt_q    <= '0;
      zero_err_q     <= 1'b0;
      rej_q          <= 1'b0;
    end else begin
      state_q        <= next_state;
      out_sent_start <= (next_state == ST_RUN) || (next_state == ST_DRAIN);
      out_sent_end   <= (next_state == ST_DRAIN) || (next_state == ST_DONE);

      if (clear_p || clr_cnt)
        elapsed_q <= '0;
      else if ((state_q == ST_RUN) && (elapsed_q != '1))
        elapsed_q <= elapsed_q + 32'd1;

      if (load_drain)
        drain_cnt_q <= drain_len;
      else if ((state_q == ST_DRAIN) && (drain_cnt_q != '0))
        drain_cnt_q <= drain_cnt_q - 32'd1;

      if (clear_p) begin
        zero_err_q <= 1'b0;
        rej_q      <= 1'b0;
      end else begin
        if (set_zero) zero_err_q <= 1'b1;
        if (set_rej)  rej_q      <= 1'b1;
      end
    end
  end

`ifdef SCM_CTRL_PKTCNT_EN
  logic [31:0] run_pkts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      run_pkts_q <= '0;
    else if (clear_p || clr_cnt)
      run_pkts_q <= '0;
    else if ((state_q == ST_RUN) && in_md_wr && (run_pkts_q != '1))
      run_pkts_q <= run_pkts_q + 32'd1;
  end

  assign run_pkts = run_pkts_q;
`else
  logic unused_md_wr;
  assign unused_md_wr = in_md_wr;
  assign run_pkts     = '0;
`endif

endmodule

// File: tb/tb_scm_meas_ctrl.sv
// Directed + randomized bench for scm_meas_ctrl with an arithmetic window model.
module tb_scm_meas_ctrl;

  localparam logic [31:0] BASE = 32'h7000_0010;
  localparam logic [2:0]  T_WR = 3'b010;
  localparam logic [2:0]  T_RD = 3'b001;

  logic         clk;
  logic         rst_n;
  logic [133:0] cin_data;
  logic         cin_data_wr;
  logic         cout_ready;
  logic [133:0] cout_data;
  logic         cout_data_wr;
  logic         cin_ready;
  logic         in_md_wr;
  logic         out_sent_start;
  logic         out_sent_end;

  int checks = 0;
  int errors = 0;

  scm_meas_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cin_data       (cin_data),
    .cin_data_wr    (cin_data_wr),
    .cout_ready     (cout_ready),
    .cout_data      (cout_data),
    .cout_data_wr   (cout_data_wr),
    .cin_ready      (cin_ready),
    .in_md_wr       (in_md_wr),
    .out_sent_start (out_sent_start),
    .out_sent_end   (out_sent_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [134:0] obs, input logic [134:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [133:0] mkword(input logic [2:0] typ, input logic [31:0] addr,
                                          input logic [31:0] data);
    logic [159:0] r;
    logic [133:0] w;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    w = r[133:0];
    w[126:124] = typ;
    w[95:64]   = addr;
    w[31:0]    = data;
    return w;
  endfunction

  // All stimulus is applied 1 time unit after a rising edge.
  task automatic send(input logic [133:0] w);
    cin_data    = w;
    cin_data_wr = 1'b1;
    @(posedge clk); #1;
    cin_data_wr = 1'b0;
  endtask

  task automatic fwd_check(input string tag, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] data);
    logic [133:0] w;
    w = mkword(typ, addr, data);
    send(w);
    check(tag, {cout_data_wr, cout_data}, {1'b1, w});
  endtask

  task automatic reg_wr(input string tag, input logic [31:0] off, input logic [31:0] data);
    fwd_check(tag, T_WR, BASE + off, data);
  endtask

  task automatic reg_rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [133:0] w;
    w = mkword(T_RD, BASE + off, $urandom());
    send(w);
    check(tag, {cout_data_wr, cout_data}, {1'b1, w[133:128], 4'b1011, w[123:32], exp});
  endtask

  // Window model: RUN lasts r cycles (WIN_LEN, or the abort cycle), DRAIN lasts
  // dd cycles (DRAIN_LEN with a minimum of one, or the second-abort cycle).
  task automatic run_window(input string tag, input int w, input int d, input int k,
                            input int j, input int rej_at, input bit md_dir);
    int  dm, r, dd, pk;
    bit  rej, md;
    dm  = (d == 0) ? 1 : d;
    r   = (k > 0) ? k : w;
    dd  = (j > 0) ? j : dm;
    pk  = 0;
    rej = 1'b0;
    reg_wr({tag, "_clr"}, 0, 32'd4);
    reg_wr({tag, "_win"}, 1, w);
    reg_wr({tag, "_drn"}, 2, d);
    reg_wr({tag, "_start"}, 0, 32'd1);
    for (int t = 1; t <= r + dd + 3; t++) begin
      check($sformatf("%s_lvl_t%0d", tag, t), {out_sent_start, out_sent_end},
            {(t <= r + dd), (t > r)});
      md = md_dir ? (((t >= 2) && (t <= 8)) || (t == 12) || (t == 13)) : 1'($urandom_range(0, 1));
      in_md_wr = md;
      if (md && (t <= r)) pk++;
      cin_data_wr = 1'b0;
      if ((k > 0) && (t == k)) begin
        cin_data = mkword(T_WR, BASE, 32'd2); cin_data_wr = 1'b1;
      end else if ((j > 0) && (t == r + j)) begin
        cin_data = mkword(T_WR, BASE, 32'd2); cin_data_wr = 1'b1;
      end else if (t == rej_at) begin
        cin_data = mkword(T_WR, BASE, 32'd1); cin_data_wr = 1'b1;
        rej = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_md_wr    = 1'b0;
    cin_data_wr = 1'b0;
    reg_rd({tag, "_status"}, 3, {27'b0, rej, 1'b0, 3'd3});
    reg_rd({tag, "_elapsed"}, 4, r);
`ifdef SCM_CTRL_PKTCNT_EN
    reg_rd({tag, "_pkts"}, 5, pk);
`else
    reg_rd({tag, "_pkts"}, 5, 32'd0);
`endif
    reg_wr({tag, "_clr2"}, 0, 32'd4);
    check({tag, "_idle"}, {out_sent_start, out_sent_end}, 2'b00);
    reg_rd({tag, "_status0"}, 3, 32'd0);
    reg_rd({tag, "_elapsed0"}, 4, 32'd0);
  endtask

  initial begin
    logic [133:0] w;
    int wl, dl, k, j, ra, r, dd;

    rst_n       = 1'b0;
    cin_ready   = 1'b1;
    cin_data    = '0;
    cin_data_wr = 1'b0;
    in_md_wr    = 1'b0;
    #1;
    check("reset_outs", {cout_data_wr, cout_data}, '0);
    check("reset_lvls", {out_sent_start, out_sent_end}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    reg_rd("rst_win", 1, 32'd0);
    reg_rd("rst_drain", 2, 32'd0);
    reg_rd("rst_status", 3, 32'd0);
    reg_rd("rst_elapsed", 4, 32'd0);
    reg_rd("rst_pkts", 5, 32'd0);
    reg_rd("ctrl_reads0", 0, 32'd0);

    run_window("basic", 10, 3, 0, 0, 0, 1'b1);
    run_window("w1d0", 1, 0, 0, 0, 0, 1'b0);
    run_window("abort", 12, 5, 4, 2, 0, 1'b0);
    run_window("rej", 8, 2, 0, 0, 3, 1'b0);

    for (int i = 0; i < 5; i++) begin
      wl = $urandom_range(1, 16);
      dl = $urandom_range(0, 5);
      k  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, wl) : 0;
      r  = (k > 0) ? k : wl;
      j  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (dl == 0) ? 1 : dl) : 0;
      dd = (j > 0) ? j : ((dl == 0) ? 1 : dl);
      ra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, r + dd) : 0;
      run_window($sformatf("rnd%0d", i), wl, dl, k, j, ra, 1'b0);
    end

    // Zero-length window
    reg_wr("z_win", 1, 32'd0);
    reg_wr("z_start", 0, 32'd1);
    check("z_lvls", {out_sent_start, out_sent_end}, 2'b00);
    reg_rd("z_status", 3, 32'h08);
    reg_wr("z_clr", 0, 32'd4);
    reg_rd("z_status0", 3, 32'h00);

    // Pass-through of foreign addresses and foreign type codes
    fwd_check("pt_rd_below", T_RD, 32'h7000_0008, $urandom());
    fwd_check("pt_wr_above", T_WR, BASE + 32'd6, 32'hDEAD_BEEF);
    reg_wr("pt_win7", 1, 32'd7);
    fwd_check("pt_type3", 3'b011, BASE + 32'd1, 32'h1234);
    fwd_check("pt_type0", 3'b000, BASE + 32'd1, 32'h5678);
    reg_rd("pt_win_kept", 1, 32'd7);
    check("pt_idle", {out_sent_start, out_sent_end}, 2'b00);

    // Back-pressure: nothing accepted while cin_ready is low
    cin_ready = 1'b0;
    cin_data  = mkword(T_WR, BASE + 32'd1, 32'd55);
    cin_data_wr = 1'b1;
    #1 check("bp_ready_low", {134'b0, cout_ready}, 135'd0);
    @(posedge clk); #1;
    check("bp_no_out", {134'b0, cout_data_wr}, 135'd0);
    cin_data = mkword(T_WR, BASE, 32'd1);
    @(posedge clk); #1;
    check("bp_no_start", {out_sent_start, out_sent_end}, 2'b00);
    check("bp_no_out2", {134'b0, cout_data_wr}, 135'd0);
    cin_data_wr = 1'b0;
    cin_ready   = 1'b1;
    #1 check("bp_ready_high", {134'b0, cout_ready}, 135'd1);
    reg_rd("bp_win_kept", 1, 32'd7);

    // CLEAR+START in a single word during RUN lands in IDLE
    reg_wr("cs_win", 1, 32'd30);
    reg_wr("cs_start", 0, 32'd1);
    check("cs_run", {out_sent_start, out_sent_end}, 2'b10);
    repeat (3) @(posedge clk);
    #1 reg_wr("cs_word", 0, 32'd5);
    check("cs_idle", {out_sent_start, out_sent_end}, 2'b00);
    reg_rd("cs_status", 3, 32'd0);

    // Reset while in DRAIN
    reg_wr("rd_win", 1, 32'd8);
    reg_wr("rd_drn", 2, 32'd10);
    reg_wr("rd_start", 0, 32'd1);
    repeat (10) @(posedge clk);
    #1 check("rd_in_drain", {out_sent_start, out_sent_end}, 2'b11);
    rst_n = 1'b0;
    #2;
    check("rd_lvls0", {out_sent_start, out_sent_end}, 2'b00);
    check("rd_outs0", {cout_data_wr, cout_data}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    reg_rd("rd_win0", 1, 32'd0);
    reg_rd("rd_drn0", 2, 32'd0);
    reg_rd("rd_status0", 3, 32'd0);
    check("rd_idle", {out_sent_start, out_sent_end}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
